// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: streams one frame of 16-bit pixels in raster order from the
// framebuffer B port onto a valid/ready pixel stream. Credit-limited read issue plus a
// small first-word-fall-through FIFO hide the 1-cycle read latency.
module framebuffer_scanout #(
  parameter int unsigned FRAME_WIDTH  = 64,
  parameter int unsigned FRAME_HEIGHT = 48,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [16:0] baseAddress,
  output logic        busy,
  output logic        done,
  output logic [16:0] fbAddress,
  output logic        fbWriteEnable,
  output logic [15:0] fbDataIn,
  input  logic [15:0] fbDataOut,
  output logic        pixelValid,
  input  logic        pixelReady,
  output logic [15:0] pixelData,
  output logic        pixelFirst,
  output logic        pixelLineEnd
);

  localparam int unsigned NumPixels = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned CntW      = $clog2(NumPixels + 1);
  localparam int unsigned XW        = $clog2(FRAME_WIDTH);
  localparam int unsigned YW        = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned FillW     = $clog2(FIFO_DEPTH + 1);

  localparam logic [CntW-1:0]  LastIdx = CntW'(NumPixels - 1);
  localparam logic [XW-1:0]    LastX   = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]    LastY   = YW'(FRAME_HEIGHT - 1);
  localparam logic [FillW:0]   Depth   = (FillW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [16:0]       fb_addr_q;
  logic [CntW-1:0]   read_idx_q;
  logic [CntW-1:0]   pix_cnt_q;
  logic              in_flight_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              done_q;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0]  fill_q;

  logic accept, issue, push, pop, credit_ok, last_pop;

  assign push      = in_flight_q;  // read data returns exactly one cycle after issue
  assign pop       = pixelValid && pixelReady;
  assign credit_ok = ({1'b0, fill_q} + (FillW + 1)'(in_flight_q)) < Depth;
  assign last_pop  = pop && (pix_cnt_q == LastIdx);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (issue && (read_idx_q == LastIdx)) state_d = StDrain;
      StDrain: if (last_pop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-derived control and constant write-side outputs
  always_comb begin
    accept        = (state_q == StIdle) && start;
    issue         = (state_q == StFetch) && credit_ok;
    busy          = (state_q != StIdle);
    fbWriteEnable = 1'b0;
    fbDataIn      = 16'h0000;
  end

  // Read address generation; fbAddress always points at base + readIndex
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fb_addr_q   <= '0;
      read_idx_q  <= '0;
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= issue;
      if (accept) begin
        fb_addr_q  <= baseAddress;
        read_idx_q <= '0;
      end else if (issue) begin
        fb_addr_q  <= fb_addr_q + 17'd1;  // 17-bit wrap is intended
        read_idx_q <= read_idx_q + CntW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fbDataOut;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      fill_q <= fill_q + FillW'(1);
      else if (pop && !push) fill_q <= fill_q - FillW'(1);
    end
  end

  // Output position counters and end-of-frame pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q       <= '0;
      y_q       <= '0;
      pix_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StDrain) && last_pop;
      if (accept) begin
        x_q       <= '0;
        y_q       <= '0;
        pix_cnt_q <= '0;
      end else if (pop) begin
        pix_cnt_q <= pix_cnt_q + CntW'(1);
        if (x_q == LastX) begin
          x_q <= '0;
          y_q <= (y_q == LastY) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // Stream outputs; flags gated by valid so they read 0 out of reset
  always_comb begin
    fbAddress    = fb_addr_q;
    done         = done_q;
    pixelValid   = (fill_q != '0);
    pixelData    = mem_q[rd_ptr_q];
    pixelFirst   = pixelValid && (x_q == '0) && (y_q == '0);
    pixelLineEnd = pixelValid && (x_q == LastX);
  end

  // The credit rule must keep the FIFO from ever overflowing
  assert property (@(posedge clk) disable iff (!resetN)
                   !(push && !pop && (fill_q == FillW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout with a behavioural synchronous-read framebuffer.
module tb_framebuffer_scanout;

  localparam int W = 64;
  localparam int H = 48;
  localparam int D = 4;
  localparam int N = W * H;

  logic        clk;
  logic        resetN;
  logic        start;
  logic [16:0] baseAddress;
  logic        busy;
  logic        done;
  logic [16:0] fbAddress;
  logic        fbWriteEnable;
  logic [15:0] fbDataIn;
  logic [15:0] fbDataOut;
  logic        pixelValid;
  logic        pixelReady;
  logic [15:0] pixelData;
  logic        pixelFirst;
  logic        pixelLineEnd;

  logic [15:0] fb_mem [131072];

  int num_checks;
  int num_errors;

  framebuffer_scanout #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .baseAddress  (baseAddress),
    .busy         (busy),
    .done         (done),
    .fbAddress    (fbAddress),
    .fbWriteEnable(fbWriteEnable),
    .fbDataIn     (fbDataIn),
    .fbDataOut    (fbDataOut),
    .pixelValid   (pixelValid),
    .pixelReady   (pixelReady),
    .pixelData    (pixelData),
    .pixelFirst   (pixelFirst),
    .pixelLineEnd (pixelLineEnd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer B port: one-cycle synchronous read
  always @(posedge clk) fbDataOut <= fb_mem[fbAddress];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},     busy,         0);
    check({tag, "_done"},     done,         0);
    check({tag, "_valid"},    pixelValid,   0);
    check({tag, "_first"},    pixelFirst,   0);
    check({tag, "_line_end"}, pixelLineEnd, 0);
    check({tag, "_addr"},     fbAddress,    0);
  endtask

  // One frame: start at base, optional random stalls, initial sink stall, ignored starts,
  // abort by reset after abort_at pixels, and exact latency checks for a continuous sink.
  task automatic run_frame(input logic [16:0] base, input int stall_pct, input int head_stall,
                           input bit ign_start, input int abort_at, input bit exact);
    int          n;
    int          k;
    bit          finished;
    bit          prev_stall;
    logic [15:0] prev_data;
    logic        prev_first;
    logic        prev_le;
    logic [16:0] offset;
    logic [16:0] addr;
    n = 0; k = 0; finished = 0; prev_stall = 0;
    prev_data = '0; prev_first = 0; prev_le = 0;
    @(negedge clk);
    start       = 1'b1;
    baseAddress = base;
    pixelReady  = (head_stall == 0);
    while (!finished) begin
      @(negedge clk);
      k++;
      start       = 1'b0;
      baseAddress = base;
      if (ign_start && (k == 10 || k == N + 2)) begin
        start       = 1'b1;
        baseAddress = base ^ 17'h05555;
      end
      if (k <= head_stall)  pixelReady = 1'b0;
      else if (stall_pct > 0) pixelReady = ($urandom_range(99) >= stall_pct);
      else                  pixelReady = 1'b1;

      if (prev_stall) begin
        check("hold_valid", pixelValid,   1);
        check("hold_data",  pixelData,    prev_data);
        check("hold_first", pixelFirst,   prev_first);
        check("hold_le",    pixelLineEnd, prev_le);
      end
      offset = fbAddress - base;
      check("credit", (int'(offset) <= n + D), 1);
      if (head_stall > 0 && k == head_stall) begin
        check("stall_addr",  fbAddress,  base + 17'd4);
        check("stall_valid", pixelValid, 1);
      end

      if (n == N) begin
        check("done",      done,       1);
        check("busy_end",  busy,       0);
        check("valid_end", pixelValid, 0);
        if (exact) check("done_cycle", k, N + 3);
        finished = 1;
      end else begin
        check("done", done, 0);
        check("busy", busy, 1);
        if (pixelValid && pixelReady) begin
          addr = base + 17'(n);
          if (exact && n == 0) check("first_cycle", k, 3);
          check("data",     pixelData,    fb_mem[addr]);
          check("first",    pixelFirst,   (n == 0));
          check("line_end", pixelLineEnd, ((n % W) == W - 1));
          n++;
          if (n == abort_at) begin
            @(posedge clk);
            #2 resetN = 1'b0;
            #1 check_reset("abort");
            @(negedge clk);
            resetN   = 1'b1;
            finished = 1;
          end
        end
        if (!finished && k > 20000) begin
          check("timeout", 0, 1);
          finished = 1;
        end
      end
      prev_stall = pixelValid && !pixelReady;
      prev_data  = pixelData;
      prev_first = pixelFirst;
      prev_le    = pixelLineEnd;
    end
  endtask

  initial begin
    num_checks  = 0;
    num_errors  = 0;
    resetN      = 1'b0;
    start       = 1'b0;
    baseAddress = '0;
    pixelReady  = 1'b0;
    for (int a = 0; a < 131072; a++) fb_mem[a] = 16'(a) ^ {a[16], 15'b0};
    repeat (2) @(negedge clk);
    check_reset("por");
    check("we",  fbWriteEnable, 0);
    check("din", fbDataIn,      0);
    resetN = 1'b1;

    run_frame(17'h00000, 0,  0,  0, -1,  1);  // continuous frame
    run_frame(17'h01000, 30, 0,  0, -1,  0);  // random backpressure
    run_frame(17'h1FFF0, 0,  0,  0, -1,  1);  // address wrap
    run_frame(17'h02000, 0,  0,  1, -1,  1);  // starts ignored while busy
    run_frame(17'h03000, 30, 0,  0, 100, 0);  // reset after 100 pixels
    run_frame(17'h04000, 0,  0,  0, -1,  1);  // clean frame after abort
    run_frame(17'h05000, 0,  20, 0, -1,  0);  // sink stalled at start

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
